alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one `alu` instance between N_REQ requesters (cores of the co-processor) using round-robin arbitration.
- Captures each requester's operation and holds the ALU inputs stable for the op's latency. Multi-cycle latency applies to multiply and to the combinational divider path.
- Returns the registered result, flags and destination to the requester that issued the op.
- Sits between the per-core issue logic and the single ALU datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width.
- OPCODE, 4, opcode width.
- REGS_CODING, 3, destination register code width.
- FLAGS, 4, flag vector width ({ZERO,OVERFLOW,SIGN,CARRY}).
- MUL_CYCLES, 2, EXEC cycles for opcode 4'b0100 (>=1).
- DIV_CYCLES, 4, EXEC cycles for opcode 4'b0101 (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- req_opcode  in  N_REQ*OPCODE  packed opcodes; requester i at [i*OPCODE +: OPCODE].
- req_op1  in  N_REQ*WIDTH  packed operand 1.
- req_op2  in  N_REQ*WIDTH  packed operand 2.
- req_cin  in  N_REQ  per-requester carry-in.
- req_dest  in  N_REQ*REGS_CODING  packed destination codes.
- gnt  out  N_REQ  one-hot, 1-cycle accept pulse.
- done  out  N_REQ  one-hot, 1-cycle response-valid pulse.
- rsp_result  out  WIDTH  result of the completed op.
- rsp_flags  out  FLAGS  flags of the completed op.
- rsp_dest  out  REGS_CODING  destination of the completed op.
- rsp_divz  out  1  completed op was a divide by zero.
- busy  out  1  high in EXEC.
- alu_en  out  1  ALU enable.
- alu_opcode  out  OPCODE  to ALU.
- alu_op1  out  WIDTH  to ALU.
- alu_op2  out  WIDTH  to ALU.
- alu_cin  out  1  to ALU.
- alu_dest  out  REGS_CODING  to ALU.
- alu_result  in  WIDTH  from ALU.
- alu_flags  in  FLAGS  from ALU.
- alu_dest_out  in  REGS_CODING  from ALU.

Behaviour:
- **States.** IDLE, EXEC, DONE.
- **Reset.** Asynchronous reset forces:
  - state to IDLE;
  - gnt, done, busy, alu_en and rsp_divz to 0;
  - all rsp_* and alu_* outputs to 0;
  - the round-robin pointer so that requester 0 has highest priority.
  
  Reset mid-EXEC aborts the op: no done is ever issued for it.
- **Arbitration.** Evaluated in IDLE and DONE.
  - Winner is the first asserted req[i] scanning from (last_winner+1) mod N_REQ upward.
  - The winner gets gnt[i]=1 for that cycle. Its opcode/op1/op2/cin/dest and its index are latched at that edge, the pointer updates, and the next state is EXEC.
  - No req: go to/stay in IDLE.
- **Requester handshake.**
  - A requester holds req and its operands until it sees gnt.
  - Dropping req before gnt withdraws the request silently.
  - req still high in the cycle after gnt counts as a new request.
- **EXEC.**
  - alu_* are driven from the latched registers; alu_en=1; busy=1.
  - A down-counter is loaded at grant with latency-1. Latency is MUL_CYCLES for 0100, DIV_CYCLES for 0101, and 1 for every other opcode.
  - When the counter reaches 0, alu_result/alu_flags/alu_dest_out are registered into rsp_* and the next state is DONE.
- **DONE.** done[owner]=1 for exactly one cycle; rsp_* hold until the next completion. Arbitration also runs in this cycle, so back-to-back throughput is 1 + latency cycles per op.
- **Latency.** A single-cycle op granted at edge T produces done at cycle T+2 (grant cycle, EXEC, DONE).
- **Divide by zero.** Opcode 0101 with latched op2==0:
  - EXEC lasts 1 cycle and the ALU output is ignored;
  - rsp_result = all ones, rsp_flags = 4'b0010 (SIGN only), rsp_divz=1;
  - rsp_divz is 0 for every other completion.
- **Outside EXEC.** alu_en=0 and alu_* keep their last values, so the ALU inputs never glitch.
- **Invariants.** gnt and done are never multi-hot. gnt and done may be high in the same cycle for different requesters, or for the same requester re-issuing.

Test Plan:
- **Reset idle:** assert rst_n=0 mid-cycle → all outputs 0 immediately. Release with no req → gnt=0, done=0, busy=0 indefinitely.
- **Single add:** req[2] with opcode 0000, op1=5, op2=7, dest=3 (ALU model) → gnt[2] at cycle 0, busy at cycle 1, done[2] at cycle 2 with rsp_result=12, rsp_dest=3, rsp_flags[ZERO]=0.
- **Round-robin fairness:** req=4'b1111 held, reasserting after each gnt → grant order 0,1,2,3,0 (or continuing from the pointer). No requester is skipped. The next gnt coincides with the previous done.
- **Multi-cycle ops:** mul 6*7 → done exactly MUL_CYCLES+1 cycles after gnt, result 42. Div 100/7 → done DIV_CYCLES+1 cycles after gnt, result 14. alu_op1/alu_op2 are stable throughout EXEC while req_op* change.
- **Divide by zero:** opcode 0101, op2=0 → done 2 cycles after gnt, rsp_result=32'hFFFFFFFF, rsp_flags=4'b0010, rsp_divz=1.
- **Withdrawal and reset mid-op:** req[1] dropped while req[0] holds the ALU → req[1] is never granted. Reset during a DIV EXEC → no done, and requester 0 is granted first after release.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares a single ALU between N_REQ requesters,
// holding the ALU inputs stable for the op latency and routing the response back.
module alu_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 32,
  parameter int OPCODE      = 4,
  parameter int REGS_CODING = 3,
  parameter int FLAGS       = 4,
  parameter int MUL_CYCLES  = 2,
  parameter int DIV_CYCLES  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*OPCODE-1:0]      req_opcode,
  input  logic [N_REQ*WIDTH-1:0]       req_op1,
  input  logic [N_REQ*WIDTH-1:0]       req_op2,
  input  logic [N_REQ-1:0]             req_cin,
  input  logic [N_REQ*REGS_CODING-1:0] req_dest,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             done,
  output logic [WIDTH-1:0]             rsp_result,
  output logic [FLAGS-1:0]             rsp_flags,
  output logic [REGS_CODING-1:0]       rsp_dest,
  output logic                         rsp_divz,
  output logic                         busy,
  output logic                         alu_en,
  output logic [OPCODE-1:0]            alu_opcode,
  output logic [WIDTH-1:0]             alu_op1,
  output logic [WIDTH-1:0]             alu_op2,
  output logic                         alu_cin,
  output logic [REGS_CODING-1:0]       alu_dest,
  input  logic [WIDTH-1:0]             alu_result,
  input  logic [FLAGS-1:0]             alu_flags,
  input  logic [REGS_CODING-1:0]       alu_dest_out
);

  localparam int IDXW   = $clog2(N_REQ);
  localparam int PW     = IDXW + 1;
  localparam int MAXLAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNTW   = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam logic [PW-1:0]     NREQ_W     = PW'(N_REQ);
  localparam logic [OPCODE-1:0] OP_MUL     = OPCODE'(4'b0100);
  localparam logic [OPCODE-1:0] OP_DIV     = OPCODE'(4'b0101);
  localparam logic [FLAGS-1:0]  DIVZ_FLAGS = FLAGS'(4'b0010);
  localparam logic [N_REQ-1:0]  ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        ptr_q, ptr_d;
  logic [IDXW-1:0]        owner_q, owner_d;
  logic [OPCODE-1:0]      opcode_q, opcode_d;
  logic [WIDTH-1:0]       op1_q, op1_d;
  logic [WIDTH-1:0]       op2_q, op2_d;
  logic                   cin_q, cin_d;
  logic [REGS_CODING-1:0] dest_q, dest_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   divz_q, divz_d;
  logic [WIDTH-1:0]       rsp_result_q, rsp_result_d;
  logic [FLAGS-1:0]       rsp_flags_q, rsp_flags_d;
  logic [REGS_CODING-1:0] rsp_dest_q, rsp_dest_d;
  logic                   rsp_divz_q, rsp_divz_d;

  logic                   win_valid_s;
  logic [IDXW-1:0]        win_idx_s;
  logic [PW-1:0]          sum_s;
  logic [IDXW-1:0]        cand_s;
  logic                   arb_en_s;
  logic [OPCODE-1:0]      win_opcode_s;
  logic [WIDTH-1:0]       win_op2_s;

  // Round-robin pick: scanning downward makes (ptr+1) the last, hence winning, overwrite.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    sum_s       = '0;
    cand_s      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum_s       = {1'b0, ptr_q} + PW'(k + 1);
      sum_s       = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
      cand_s      = sum_s[IDXW-1:0];
      win_idx_s   = req[cand_s] ? cand_s : win_idx_s;
      win_valid_s = win_valid_s | req[cand_s];
    end
  end

  assign arb_en_s     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign win_opcode_s = req_opcode[int'(win_idx_s)*OPCODE +: OPCODE];
  assign win_op2_s    = req_op2[int'(win_idx_s)*WIDTH +: WIDTH];

  // Next-state, operand capture, latency counting and response capture.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    opcode_d     = opcode_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    cin_d        = cin_q;
    dest_d       = dest_q;
    cnt_d        = cnt_q;
    divz_d       = divz_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_dest_d   = rsp_dest_q;
    rsp_divz_d   = rsp_divz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (win_valid_s) begin
          state_d  = S_EXEC;
          ptr_d    = win_idx_s;
          owner_d  = win_idx_s;
          opcode_d = win_opcode_s;
          op1_d    = req_op1[int'(win_idx_s)*WIDTH +: WIDTH];
          op2_d    = win_op2_s;
          cin_d    = req_cin[win_idx_s];
          dest_d   = req_dest[int'(win_idx_s)*REGS_CODING +: REGS_CODING];
          divz_d   = (win_opcode_s == OP_DIV) && (win_op2_s == '0);
          // A divide by zero skips the divider, so it completes in one cycle.
          if (win_opcode_s == OP_MUL) begin
            cnt_d = CNTW'(MUL_CYCLES - 1);
          end else if ((win_opcode_s == OP_DIV) && (win_op2_s != '0)) begin
            cnt_d = CNTW'(DIV_CYCLES - 1);
          end else begin
            cnt_d = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d    = S_DONE;
          rsp_divz_d = divz_q;
          if (divz_q) begin
            rsp_result_d = '1;
            rsp_flags_d  = DIVZ_FLAGS;
            rsp_dest_d   = dest_q;
          end else begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rsp_dest_d   = alu_dest_out;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves requester 0 at top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= IDXW'(N_REQ - 1);
      owner_q      <= '0;
      opcode_q     <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      cin_q        <= 1'b0;
      dest_q       <= '0;
      cnt_q        <= '0;
      divz_q       <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_dest_q   <= '0;
      rsp_divz_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      opcode_q     <= opcode_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      cin_q        <= cin_d;
      dest_q       <= dest_d;
      cnt_q        <= cnt_d;
      divz_q       <= divz_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_dest_q   <= rsp_dest_d;
      rsp_divz_q   <= rsp_divz_d;
    end
  end

  // gnt is qualified by rst_n so a held request cannot show a grant during reset.
  assign gnt        = (arb_en_s && win_valid_s && rst_n) ? (ONE_HOT0 << win_idx_s) : '0;
  assign done       = (state_q == S_DONE) ? (ONE_HOT0 << owner_q) : '0;
  assign busy       = (state_q == S_EXEC);
  assign alu_en     = (state_q == S_EXEC);
  assign alu_opcode = opcode_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_cin    = cin_q;
  assign alu_dest   = dest_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_dest   = rsp_dest_q;
  assign rsp_divz   = rsp_divz_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to its ALU port.
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*4-1:0] req_opcode = '0;
  logic [N*W-1:0] req_op1 = '0;
  logic [N*W-1:0] req_op2 = '0;
  logic [N-1:0]   req_cin = '0;
  logic [N*3-1:0] req_dest = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   rsp_result, alu_op1, alu_op2, alu_result;
  logic [3:0]     rsp_flags, alu_opcode, alu_flags;
  logic [2:0]     rsp_dest, alu_dest, alu_dest_out;
  logic           rsp_divz, busy, alu_en, alu_cin;
  logic [W:0]     sum_m;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_opcode(req_opcode),
    .req_op1(req_op1), .req_op2(req_op2), .req_cin(req_cin), .req_dest(req_dest),
    .gnt(gnt), .done(done), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_dest(rsp_dest), .rsp_divz(rsp_divz), .busy(busy), .alu_en(alu_en),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_cin(alu_cin), .alu_dest(alu_dest), .alu_result(alu_result),
    .alu_flags(alu_flags), .alu_dest_out(alu_dest_out)
  );

  always #5 clk = ~clk;

  // ALU model; its divide-by-zero output differs from the arbiter's substitute.
  always_comb begin
    sum_m      = '0;
    alu_result = '0;
    alu_flags  = 4'b0000;
    case (alu_opcode)
      4'b0000: begin
        sum_m      = {1'b0, alu_op1} + {1'b0, alu_op2} + {32'd0, alu_cin};
        alu_result = sum_m[W-1:0];
        alu_flags  = {(sum_m[W-1:0] == 32'd0),
                      (alu_op1[31] == alu_op2[31]) && (sum_m[31] != alu_op1[31]),
                      sum_m[31], sum_m[W]};
      end
      4'b0100: begin
        alu_result = alu_op1 * alu_op2;
        alu_flags  = {(alu_result == 32'd0), 1'b0, alu_result[31], 1'b0};
      end
      4'b0101: begin
        alu_result = (alu_op2 == 32'd0) ? 32'd0 : (alu_op1 / alu_op2);
        alu_flags  = (alu_op2 == 32'd0) ? 4'b1001 : {(alu_result == 32'd0), 2'b00, 1'b0};
      end
      default: begin
        alu_result = alu_op1 & alu_op2;
        alu_flags  = {(alu_result == 32'd0), 1'b0, alu_result[31], 1'b0};
      end
    endcase
  end
  assign alu_dest_out = alu_dest;

  wire [W*3+4+4+3+3+3+N*2+4-1:0] all_out = {gnt, done, busy, alu_en, rsp_divz, rsp_result,
                                            rsp_flags, rsp_dest, alu_opcode, alu_op1,
                                            alu_op2, alu_cin, alu_dest};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] d);
    req_opcode[i*4 +: 4] = opc;
    req_op1[i*W +: W]    = a;
    req_op2[i*W +: W]    = b;
    req_dest[i*3 +: 3]   = d;
    req_cin[i]           = 1'b0;
    req[i]               = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", all_out);
    end
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++;
      if ({gnt, done, busy} !== 9'd0) begin
        errors++; $display("FAIL reset_idle cycle %0d got %b want 0", c, {gnt, done, busy});
      end
      tick();
    end
  endtask

  task automatic test_single_add();
    set_req(2, 4'b0000, 32'd5, 32'd7, 3'd3);
    sample();
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b0) begin
      errors++; $display("FAIL add_gnt got gnt=%b busy=%b want 0100/0", gnt, busy);
    end
    tick();
    req = '0;
    sample();
    checks++;
    if ({busy, alu_en, gnt, done} !== 10'b11_0000_0000 || alu_op1 !== 32'd5 ||
        alu_op2 !== 32'd7 || alu_dest !== 3'd3 || alu_opcode !== 4'b0000) begin
      errors++; $display("FAIL add_exec got busy=%b en=%b op1=%0d op2=%0d dest=%0d want 1/1/5/7/3",
                         busy, alu_en, alu_op1, alu_op2, alu_dest);
    end
    tick();
    sample();
    checks++;
    if (done !== 4'b0100 || rsp_result !== 32'd12 || rsp_dest !== 3'd3 ||
        rsp_flags !== 4'b0000 || rsp_divz !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL add_done got done=%b res=%0d dest=%0d flags=%b divz=%b want 0100/12/3/0000/0",
                         done, rsp_result, rsp_dest, rsp_flags, rsp_divz);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_gnt [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] exp_res [5] = '{32'd49, 32'd1, 32'd17, 32'd33, 32'd49};
    for (int i = 0; i < N; i++) set_req(i, 4'b0000, 32'(i * 16), 32'd1, 3'(i));
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++;
      if (gnt !== exp_gnt[k]) begin
        errors++; $display("FAIL rr_gnt step %0d got %b want %b", k, gnt, exp_gnt[k]);
      end
      if (k > 0) begin
        checks++;
        if (done !== exp_gnt[k-1] || rsp_result !== exp_res[k-1]) begin
          errors++; $display("FAIL rr_done step %0d got %b/%0d want %b/%0d",
                             k, done, rsp_result, exp_gnt[k-1], exp_res[k-1]);
        end
      end
      tick();
      if (k == 4) req = '0;
      sample();
      checks++;
      if (busy !== 1'b1 || gnt !== 4'b0000) begin
        errors++; $display("FAIL rr_exec step %0d got busy=%b gnt=%b want 1/0000", k, busy, gnt);
      end
      tick();
    end
    sample();
    checks++;
    if (done !== 4'b1000 || rsp_result !== 32'd49 || gnt !== 4'b0000) begin
      errors++; $display("FAIL rr_last got done=%b res=%0d gnt=%b want 1000/49/0000", done, rsp_result, gnt);
    end
    tick();
  endtask

  task automatic test_multicycle();
    int          idx  [2] = '{1, 0};
    logic [3:0]  opc  [2] = '{4'b0100, 4'b0101};
    logic [31:0] a    [2] = '{32'd6, 32'd100};
    logic [31:0] b    [2] = '{32'd7, 32'd7};
    int          lat  [2] = '{2, 4};
    logic [31:0] res  [2] = '{32'd42, 32'd14};
    logic [3:0]  gv   [2] = '{4'b0010, 4'b0001};
    for (int t = 0; t < 2; t++) begin
      set_req(idx[t], opc[t], a[t], b[t], 3'd6);
      sample();
      checks++;
      if (gnt !== gv[t]) begin
        errors++; $display("FAIL mc_gnt op %0d got %b want %b", t, gnt, gv[t]);
      end
      tick();
      req = '0;
      req_op1 = {N{32'hDEADBEEF}};
      req_op2 = {N{32'h12345678}};
      for (int c = 1; c <= lat[t]; c++) begin
        sample();
        checks++;
        if (busy !== 1'b1 || done !== 4'b0000 || alu_op1 !== a[t] || alu_op2 !== b[t]) begin
          errors++; $display("FAIL mc_exec op %0d cycle %0d got busy=%b done=%b op1=%0d op2=%0d want 1/0000/%0d/%0d",
                             t, c, busy, done, alu_op1, alu_op2, a[t], b[t]);
        end
        tick();
      end
      sample();
      checks++;
      if (done !== gv[t] || rsp_result !== res[t] || rsp_dest !== 3'd6) begin
        errors++; $display("FAIL mc_done op %0d got done=%b res=%0d dest=%0d want %b/%0d/6",
                           t, done, rsp_result, rsp_dest, gv[t], res[t]);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    set_req(2, 4'b0101, 32'd55, 32'd0, 3'd5);
    sample();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL dz_gnt got %b want 0100", gnt);
    end
    tick();
    req = '0;
    sample();
    checks++;
    if (busy !== 1'b1 || done !== 4'b0000) begin
      errors++; $display("FAIL dz_exec got busy=%b done=%b want 1/0000", busy, done);
    end
    tick();
    sample();
    checks++;
    if (done !== 4'b0100 || rsp_result !== 32'hFFFFFFFF || rsp_flags !== 4'b0010 ||
        rsp_divz !== 1'b1 || rsp_dest !== 3'd5) begin
      errors++; $display("FAIL dz_done got done=%b res=%h flags=%b divz=%b dest=%0d want 0100/ffffffff/0010/1/5",
                         done, rsp_result, rsp_flags, rsp_divz, rsp_dest);
    end
    tick();
  endtask

  task automatic test_withdraw();
    set_req(0, 4'b0101, 32'd100, 32'd7, 3'd1);
    set_req(1, 4'b0000, 32'd1, 32'd1, 3'd2);
    sample();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL wd_gnt got %b want 0001", gnt);
    end
    tick();
    req = '0;
    for (int c = 0; c < 4; c++) begin
      sample();
      checks++;
      if (gnt !== 4'b0000) begin
        errors++; $display("FAIL wd_exec cycle %0d got gnt=%b want 0000", c, gnt);
      end
      tick();
    end
    sample();
    checks++;
    if (done !== 4'b0001 || rsp_result !== 32'd14 || rsp_divz !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL wd_done got done=%b res=%0d divz=%b gnt=%b want 0001/14/0/0000",
                         done, rsp_result, rsp_divz, gnt);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (gnt !== 4'b0000 || done !== 4'b0000) begin
        errors++; $display("FAIL wd_after cycle %0d got gnt=%b done=%b want 0000/0000", c, gnt, done);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    set_req(0, 4'b0101, 32'd100, 32'd7, 3'd1);
    sample();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL rm_gnt got %b want 0001", gnt);
    end
    tick();
    req = '0;
    sample();
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL rm_async got %h want 0", all_out);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      checks++;
      if (done !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("FAIL rm_nodone cycle %0d got done=%b busy=%b want 0000/0", c, done, busy);
      end
      tick();
    end
    set_req(0, 4'b0000, 32'd1, 32'd2, 3'd0);
    set_req(1, 4'b0000, 32'd3, 32'd4, 3'd0);
    sample();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL rm_prio got %b want 0001", gnt);
    end
    tick();
    req = '0;
    sample();
    tick();
    sample();
    checks++;
    if (done !== 4'b0001 || rsp_result !== 32'd3) begin
      errors++; $display("FAIL rm_done got done=%b res=%0d want 0001/3", done, rsp_result);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_multicycle();
    test_div_zero();
    test_withdraw();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
